fft_frame_sequencer: RTL and testbench

- Parametrised FIFO-to-FFT frame controller. It fills NUM_CH show-ahead sample FIFOs, then streams one FFT_LEN-point frame per channel, in channel order, into a single Avalon-ST FFT core.
- Honours sink_ready per beat and generates exact sop/eop on beats 0 and FFT_LEN-1.
- Adds single-shot or continuous operation, a per-frame inverse flag, a channel tag, frame counting and underrun detection.
- Sits between the ADC capture FIFOs and the FFT IP.

---
 rtl/fft_seq_pkg.sv | 29 ++
 rtl/fft_beat_counter.sv | 45 ++++
 rtl/fft_frame_sequencer.sv | 170 +++++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_seq_pkg.sv
// ---------------------------------------------------------------
// fft_seq_pkg : shared types and helpers for the FFT frame sequencer
// Revision    : 1.0
// ---------------------------------------------------------------
`default_nettype none

package fft_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FILL     = 2'd1,
    S_WAIT_RDY = 2'd2,
    S_STREAM   = 2'd3
  } state_t;

  localparam int unsigned MAX_CH      = 8;
  localparam int unsigned CH_IDX_W    = $clog2(MAX_CH);
  localparam int unsigned MAX_FFT_LEN = 65536;
  localparam int unsigned FRAME_CNT_W = $clog2(MAX_FFT_LEN);

  // True when channel index ch addresses FIFO idx.
  function automatic logic ch_sel(input logic [CH_IDX_W-1:0] ch,
                                  input logic [CH_IDX_W-1:0] idx);
    return ch == idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_beat_counter.sv
// ---------------------------------------------------------------
// fft_beat_counter : per-frame beat counter with first/last flags
// Revision         : 1.0
// ---------------------------------------------------------------
`default_nettype none

module fft_beat_counter #(
  parameter int FFT_LEN = 4096,
  parameter int CNT_W   = $clog2(FFT_LEN)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic inc_i,
  output logic first_o,
  output logic last_o
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FFT_LEN - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = (count_q == LAST_BEAT) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign first_o = (count_q == '0);
  assign last_o  = (count_q == LAST_BEAT);

endmodule

`default_nettype wire

// File: rtl/fft_frame_sequencer.sv
// ---------------------------------------------------------------
// fft_frame_sequencer : fills channel FIFOs, then streams one frame
//                       per channel into an Avalon-ST FFT sink
// Revision            : 1.0
// ---------------------------------------------------------------
`default_nettype none

module fft_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter int FFT_LEN = 4096,
  parameter int NUM_CH  = 2,
  parameter int DATA_W  = 16,
  parameter int CNT_W   = $clog2(FFT_LEN),
  parameter int CH_W    = (NUM_CH > 1 ? $clog2(NUM_CH) : 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     mode_cont,
  input  logic                     inverse_in,
  input  logic                     clear_err,
  output logic [NUM_CH-1:0]        wr_fifo_en,
  output logic [NUM_CH-1:0]        rd_fifo_en,
  input  logic [NUM_CH-1:0]        wrfull,
  input  logic [NUM_CH-1:0]        rdempty,
  input  logic [NUM_CH*DATA_W-1:0] fifo_q,
  input  logic                     sink_ready,
  output logic                     sink_valid,
  output logic                     sink_sop,
  output logic                     sink_eop,
  output logic [DATA_W-1:0]        sink_real,
  output logic                     sink_inverse,
  output logic [CH_W-1:0]          sink_channel,
  output logic                     frame_done,
  output logic [FRAME_CNT_W-1:0]   frame_cnt,
  output logic                     busy,
  output logic                     underrun_err
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  state_t                   state_q, state_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic [NUM_CH-1:0]        wr_en_q, wr_en_d;
  logic                     inv_q, inv_d;
  logic                     done_q;
  logic [FRAME_CNT_W-1:0]   cnt_q;
  logic                     err_q, err_d;

  logic                     beat_first, beat_last;
  logic                     accept, last_accept, underrun_set;
  logic [DATA_W-1:0]        ch_data [NUM_CH];

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign ch_data[k]    = fifo_q[k*DATA_W +: DATA_W];
      assign rd_fifo_en[k] = accept && ch_sel(CH_IDX_W'(ch_q), CH_IDX_W'(k));
    end
  endgenerate

  fft_beat_counter #(
    .FFT_LEN (FFT_LEN),
    .CNT_W   (CNT_W)
  ) u_beat (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (state_q != S_STREAM),
    .inc_i   (accept),
    .first_o (beat_first),
    .last_o  (beat_last)
  );

  assign sink_valid   = (state_q == S_STREAM) && !rdempty[ch_q];
  assign accept       = sink_valid && sink_ready;
  assign sink_sop     = sink_valid && beat_first;
  assign sink_eop     = sink_valid && beat_last;
  assign last_accept  = accept && beat_last;
  assign sink_real    = ch_data[ch_q];
  // The sop beat itself sees the live request; later beats see the latch.
  assign sink_inverse = sink_sop ? inverse_in : inv_q;
  assign sink_channel = ch_q;
  assign wr_fifo_en   = (state_q == S_FILL) ? wr_en_q : '0;
  assign frame_done   = done_q;
  assign frame_cnt    = cnt_q;
  assign busy         = (state_q != S_IDLE);
  assign underrun_err = err_q;

  assign underrun_set = (state_q == S_STREAM) && rdempty[ch_q] && !beat_first;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    wr_en_d = wr_en_q;
    inv_d   = inv_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FILL;
          wr_en_d = '1;
        end
      end
      S_FILL: begin
        wr_en_d = wr_en_q & ~wrfull;
        if (&wrfull) begin
          state_d = S_WAIT_RDY;
          ch_d    = '0;
          wr_en_d = '0;
        end
      end
      S_WAIT_RDY: begin
        if (sink_ready) begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (last_accept) begin
          if (ch_q == LAST_CH) begin
            ch_d = '0;
            if (mode_cont) begin
              state_d = S_FILL;
              wr_en_d = '1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            ch_d = ch_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (accept && beat_first) begin
      inv_d = inverse_in;
    end
  end

  // Set has priority over clear so a concurrent underrun is never lost.
  always_comb begin
    err_d = err_q;
    if (underrun_set) begin
      err_d = 1'b1;
    end else if (clear_err) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      wr_en_q <= '0;
      inv_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      wr_en_q <= wr_en_d;
      inv_q   <= inv_d;
      done_q  <= last_accept;
      cnt_q   <= cnt_q + FRAME_CNT_W'(last_accept);
      err_q   <= err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fft_frame_sequencer.sv
// ---------------------------------------------------------------
// tb_fft_frame_sequencer : directed bench with two show-ahead FIFO models
// Revision               : 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_fft_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode_cont = 1'b0;
  logic        inverse_in = 1'b0;
  logic        clear_err = 1'b0;
  logic [1:0]  wr_fifo_en, rd_fifo_en;
  logic [1:0]  wrfull, rdempty;
  logic [31:0] fifo_q;
  logic        sink_ready = 1'b1;
  logic        sink_valid, sink_sop, sink_eop, sink_inverse, frame_done, busy, underrun_err;
  logic [15:0] sink_real, frame_cnt;
  logic        sink_channel;
  logic [1:0]  force_empty = 2'b00;

  int errors = 0;
  int checks = 0;
  int exp_frames = 0;
  int ch_frame [2];

  // Show-ahead FIFO models; channel k writes k*256 + running sequence.
  logic [15:0] mem [2][8];
  int wp [2], rp [2], cnt [2], wseq [2];

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        wp[k] <= 0; rp[k] <= 0; cnt[k] <= 0; wseq[k] <= 0;
      end else begin
        if (wr_fifo_en[k] && cnt[k] < 8) begin
          mem[k][wp[k]] <= 16'(k*256 + wseq[k]);
          wp[k]   <= (wp[k] + 1) % 8;
          wseq[k] <= wseq[k] + 1;
        end
        if (rd_fifo_en[k] && cnt[k] > 0) rp[k] <= (rp[k] + 1) % 8;
        cnt[k] <= cnt[k] + ((wr_fifo_en[k] && cnt[k] < 8) ? 1 : 0)
                         - ((rd_fifo_en[k] && cnt[k] > 0) ? 1 : 0);
      end
    end
  end

  always_comb begin
    wrfull  = {cnt[1] == 8, cnt[0] == 8};
    rdempty = {cnt[1] == 0, cnt[0] == 0} | force_empty;
    fifo_q  = {mem[1][rp[1]], mem[0][rp[0]]};
  end

  fft_frame_sequencer #(.FFT_LEN(8), .NUM_CH(2), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_cont(mode_cont),
    .inverse_in(inverse_in), .clear_err(clear_err),
    .wr_fifo_en(wr_fifo_en), .rd_fifo_en(rd_fifo_en), .wrfull(wrfull),
    .rdempty(rdempty), .fifo_q(fifo_q), .sink_ready(sink_ready),
    .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_real(sink_real), .sink_inverse(sink_inverse), .sink_channel(sink_channel),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .busy(busy),
    .underrun_err(underrun_err)
  );

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; mode_cont = 1'b0; clear_err = 1'b0;
    sink_ready = 1'b1; force_empty = 2'b00; inverse_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_frames = 0; ch_frame[0] = 0; ch_frame[1] = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    #1;
  endtask

  // Streams one frame, optionally stalling or starving it at given beats.
  task automatic stream_frame(input int ch, input logic exp_inv,
                              input int stall_beat, input int stall_len,
                              input int empty_beat, input int empty_len);
    int beat = 0, st = 0, et = 0, budget = 0;
    logic stalling, starving;
    logic [15:0] exp_d;
    while (beat < 8 && budget < 200) begin
      @(negedge clk);
      budget++;
      exp_d = 16'(ch*256 + ch_frame[ch]*8 + beat);
      inverse_in = (beat < 2) ? exp_inv : ~exp_inv;
      stalling = (beat == stall_beat && st < stall_len);
      starving = (beat == empty_beat && et < empty_len);
      if (stalling) st++;
      if (starving) et++;
      sink_ready = !stalling;
      force_empty = 2'b00;
      if (starving) force_empty[ch] = 1'b1;
      #1;
      if (stalling) begin
        checks++;
        if (rd_fifo_en !== 2'b00 || sink_valid !== 1'b1 || sink_real !== exp_d) begin
          errors++;
          $display("FAIL stall_hold ch%0d beat%0d: rd_en=%b valid=%b data=%h, required 00/1/%h",
                   ch, beat, rd_fifo_en, sink_valid, sink_real, exp_d);
        end
      end
      if (starving) begin
        checks++;
        if (sink_valid !== 1'b0 || rd_fifo_en !== 2'b00) begin
          errors++;
          $display("FAIL underrun_stall ch%0d beat%0d: valid=%b rd_en=%b, required 0/00",
                   ch, beat, sink_valid, rd_fifo_en);
        end
      end
      if (sink_valid === 1'b1 && sink_ready) begin
        checks++;
        if (sink_sop !== (beat == 0) || sink_eop !== (beat == 7) ||
            sink_channel !== 1'(ch) || sink_inverse !== exp_inv ||
            rd_fifo_en !== (2'b01 << ch) || (beat > 0 && frame_done !== 1'b0)) begin
          errors++;
          $display("FAIL beat_ctrl ch%0d beat%0d: sop=%b eop=%b chan=%0d inv=%b rd=%b done=%b, required %b/%b/%0d/%b/%b/0",
                   ch, beat, sink_sop, sink_eop, sink_channel, sink_inverse, rd_fifo_en,
                   frame_done, beat == 0, beat == 7, ch, exp_inv, 2'b01 << ch);
        end
        checks++;
        if (sink_real !== exp_d) begin
          errors++;
          $display("FAIL beat_data ch%0d beat%0d: got %h, required %h", ch, beat, sink_real, exp_d);
        end
        beat++;
      end
    end
    checks++;
    if (beat < 8) begin
      errors++;
      $display("FAIL frame_timeout ch%0d: %0d beats accepted, required 8", ch, beat);
    end
    force_empty = 2'b00;
    @(posedge clk); #1;
    exp_frames++;
    ch_frame[ch]++;
    checks++;
    if (frame_done !== 1'b1 || frame_cnt !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL frame_done ch%0d: done=%b cnt=%0d, required 1/%0d", ch, frame_done, frame_cnt, exp_frames);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (sink_valid !== 1'b0 || sink_sop !== 1'b0 || sink_eop !== 1'b0 ||
        sink_inverse !== 1'b0 || frame_done !== 1'b0 || sink_channel !== 1'b0) begin
      errors++;
      $display("FAIL reset_sink: valid=%b sop=%b eop=%b inv=%b done=%b chan=%b, required all 0",
               sink_valid, sink_sop, sink_eop, sink_inverse, frame_done, sink_channel);
    end
    checks++;
    if (frame_cnt !== 16'd0 || underrun_err !== 1'b0 || busy !== 1'b0 ||
        wr_fifo_en !== 2'b00 || rd_fifo_en !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: cnt=%0d err=%b busy=%b wr=%b rd=%b, required 0/0/0/00/00",
               frame_cnt, underrun_err, busy, wr_fifo_en, rd_fifo_en);
    end
    start = 1'b0;
    do_reset();
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_basic();
    do_reset();
    pulse_start();
    checks++;
    if (busy !== 1'b1 || wr_fifo_en !== 2'b11) begin
      errors++;
      $display("FAIL basic_fill: busy=%b wr=%b, required 1/11", busy, wr_fifo_en);
    end
    stream_frame(0, 1'b0, -1, 0, -1, 0);
    stream_frame(1, 1'b0, -1, 0, -1, 0);
    checks++;
    if (busy !== 1'b0 || frame_cnt !== 16'd2 || underrun_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_end: busy=%b cnt=%0d err=%b, required 0/2/0", busy, frame_cnt, underrun_err);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    pulse_start();
    stream_frame(0, 1'b0, 3, 5, -1, 0);
    stream_frame(1, 1'b0, 5, 3, -1, 0);
    checks++;
    if (busy !== 1'b0 || frame_cnt !== 16'd2) begin
      errors++;
      $display("FAIL bp_end: busy=%b cnt=%0d, required 0/2", busy, frame_cnt);
    end
  endtask

  task automatic test_continuous();
    do_reset();
    mode_cont = 1'b1;
    pulse_start();
    stream_frame(0, 1'b0, -1, 0, -1, 0);
    stream_frame(1, 1'b0, -1, 0, -1, 0);
    checks++;
    if (busy !== 1'b1 || wr_fifo_en !== 2'b11) begin
      errors++;
      $display("FAIL cont_refill: busy=%b wr=%b, required 1/11", busy, wr_fifo_en);
    end
    mode_cont = 1'b0;
    stream_frame(0, 1'b0, -1, 0, -1, 0);
    stream_frame(1, 1'b0, -1, 0, -1, 0);
    checks++;
    if (busy !== 1'b0 || frame_cnt !== 16'd4) begin
      errors++;
      $display("FAIL cont_stop: busy=%b cnt=%0d, required 0/4", busy, frame_cnt);
    end
  endtask

  task automatic test_inverse();
    do_reset();
    pulse_start();
    stream_frame(0, 1'b1, -1, 0, -1, 0);
    stream_frame(1, 1'b0, -1, 0, -1, 0);
  endtask

  task automatic test_underrun();
    do_reset();
    pulse_start();
    stream_frame(0, 1'b0, -1, 0, 4, 2);
    checks++;
    if (underrun_err !== 1'b1) begin
      errors++;
      $display("FAIL underrun_set: err=%b, required 1", underrun_err);
    end
    stream_frame(1, 1'b0, -1, 0, -1, 0);
    @(negedge clk); clear_err = 1'b1;
    @(negedge clk); clear_err = 1'b0;
    #1;
    checks++;
    if (underrun_err !== 1'b0) begin
      errors++;
      $display("FAIL underrun_clear: err=%b, required 0", underrun_err);
    end
  endtask

  task automatic test_reset_mid_stream();
    int beat = 0, budget = 0;
    do_reset();
    pulse_start();
    stream_frame(0, 1'b0, -1, 0, -1, 0);
    while (beat < 5 && budget < 100) begin
      @(negedge clk);
      budget++;
      sink_ready = 1'b1; inverse_in = 1'b0;
      #1;
      if (sink_valid === 1'b1) beat++;
    end
    @(negedge clk); #1;
    checks++;
    if (sink_channel !== 1'b1 || frame_cnt !== 16'd1 || beat != 5) begin
      errors++;
      $display("FAIL mid_pre: chan=%b cnt=%0d beats=%0d, required 1/1/5", sink_channel, frame_cnt, beat);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (sink_valid !== 1'b0 || sink_channel !== 1'b0 || frame_cnt !== 16'd0 ||
        busy !== 1'b0 || rd_fifo_en !== 2'b00 || sink_sop !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b chan=%b cnt=%0d busy=%b rd=%b sop=%b, required 0/0/0/0/00/0",
               sink_valid, sink_channel, frame_cnt, busy, rd_fifo_en, sink_sop);
    end
    do_reset();
    pulse_start();
    stream_frame(0, 1'b0, -1, 0, -1, 0);
    stream_frame(1, 1'b0, -1, 0, -1, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_continuous();
    test_inverse();
    test_underrun();
    test_reset_mid_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
